// File: rtl/imm_ext_unit.sv
// ---------------------------------------------------------------------------
// imm_ext_unit
//   Parametrised immediate extender with a valid/ready handshake and a
//   registered result. It takes the place of the fixed 16->32 extender that
//   sat between instruction decode and the ALU B-operand mux / branch-offset
//   adder.
//
//   Modes (eop):
//     00  sign-extend imm to OUT_W bits
//     01  zero-extend imm to OUT_W bits
//     10  load-upper: imm placed in the top IMM_W bits, zeros below
//     11  sign-extend, then logical left shift by shamt. The shift runs one
//         bit per cycle in the SHIFT state, so latency is 1+shamt cycles.
//
//   Optional feature: define IMM_EXT_OVF_EN to add the sticky signed-overflow
//   output 'ovf'. Without the macro the port and its logic are absent.
//
// Ports
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous reset, active-low (0 = reset)
//   in_valid   in   1        request valid
//   in_ready   out  1        request accepted when in_valid & in_ready
//   imm        in   IMM_W    immediate field
//   eop        in   2        extension mode (see above)
//   shamt      in   SHAMT_W  left-shift amount, mode 11 only
//   out_valid  out  1        ext holds a result
//   out_ready  in   1        consumer takes the result when out_valid & out_ready
//   ext        out  OUT_W    extended result (registered)
//   busy       out  1        1 while shifting
//   ovf        out  1        (IMM_EXT_OVF_EN only) sticky signed overflow
// ---------------------------------------------------------------------------
module imm_ext_unit #(
    parameter int IMM_W   = 16,
    parameter int OUT_W   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IMM_W-1:0]   imm,
    input  logic [1:0]         eop,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   ext,
    output logic               busy
`ifdef IMM_EXT_OVF_EN
    ,
    output logic               ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [OUT_W-1:0]   r_ext;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_out_valid;
    logic               r_busy;
`ifdef IMM_EXT_OVF_EN
    logic               r_ovf;
`endif

    logic               w_accept;
    logic               w_to_shift;
    logic [OUT_W-1:0]   w_sext;
    logic [OUT_W-1:0]   w_zext;
    logic [OUT_W-1:0]   w_result;

    // A new request can enter when idle, or when the held result is being
    // consumed in this very cycle (pass-through accept). Held low in reset.
    assign in_ready   = reset & ((r_state == S_IDLE) | ((r_state == S_HOLD) & out_ready));
    assign w_accept   = in_valid & in_ready;
    assign w_to_shift = (eop == 2'b11) && (shamt != '0);

    assign w_sext = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign w_zext = {{(OUT_W-IMM_W){1'b0}}, imm};

    always_comb begin
        // NOTE: default first so every path assigns w_result; no latch is inferred.
        w_result = w_sext;
        case (eop)
            2'b01:   w_result = w_zext;
            2'b10:   w_result = w_zext << (OUT_W - IMM_W);
            default: w_result = w_sext;  // 00, and 11 before shifting
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ext       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef IMM_EXT_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else if (w_accept) begin
            // Covers both IDLE accepts and the HOLD pass-through accept.
            r_ext <= w_result;
            r_cnt <= (eop == 2'b11) ? shamt : '0;
`ifdef IMM_EXT_OVF_EN
            r_ovf <= 1'b0;
`endif
            if (w_to_shift) begin
                r_state     <= S_SHIFT;
                r_busy      <= 1'b1;
                r_out_valid <= 1'b0;
            end else begin
                r_state     <= S_HOLD;
                r_busy      <= 1'b0;
                r_out_valid <= 1'b1;
            end
        end else begin
            case (r_state)
                S_SHIFT: begin
                    r_ext <= r_ext << 1;
                    r_cnt <= r_cnt - SHAMT_W'(1);
`ifdef IMM_EXT_OVF_EN
                    // Sign bit about to be replaced by a differing bit.
                    if (r_ext[OUT_W-1] != r_ext[OUT_W-2]) begin
                        r_ovf <= 1'b1;
                    end
`endif
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_state     <= S_HOLD;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                S_IDLE: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign ext       = r_ext;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
`ifdef IMM_EXT_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule
